// File: rtl/rx_pkg.sv
// Shared receive-chain definitions: sample/gain formats, saturation limits and the AGC state set.
package rx_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int GAIN_W    = 12;                      // unsigned Q4.8
  localparam int GAIN_FRAC = 8;
  localparam int PROD_W    = SAMPLE_W + GAIN_W + 1;   // signed sample x unsigned gain
  localparam int MAG_W     = SAMPLE_W + 1;            // |I| + |Q|

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    AGC_IDLE  = 2'd0,
    AGC_TRACK = 2'd1,
    AGC_HOLD  = 2'd2
  } agc_state_e;

  // Magnitude with the most negative code folded onto full scale so it fits SAMPLE_W bits.
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] x);
    if (x == SAT_MIN)   return SAT_MAX;
    else if (x < 0)     return -x;
    else                return x;
  endfunction

endpackage

// File: rtl/agc_scale.sv
// Two-stage gain pipeline for one rail: multiply, then round-half-up and saturate to 16 bits.
module agc_scale
  import rx_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic signed [SAMPLE_W-1:0] in_x,
  input  logic        [GAIN_W-1:0]   gain,
  output logic signed [SAMPLE_W-1:0] out_x,
  output logic                       out_vld
);

  localparam logic signed [PROD_W-1:0] RND = PROD_W'(2 ** (GAIN_FRAC - 1));
  localparam logic signed [PROD_W-1:0] HI  = PROD_W'(SAT_MAX);
  localparam logic signed [PROD_W-1:0] LO  = PROD_W'(SAT_MIN);

  logic signed [PROD_W-1:0]   prod_q;
  logic signed [PROD_W-1:0]   rnd;
  logic signed [SAMPLE_W-1:0] sat_x;
  logic                       vld1_q;

  // NOTE: the product register carries no reset; vld1_q qualifies it, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (in_vld) prod_q <= in_x * $signed({1'b0, gain});
  end

  always_ff @(posedge clk) begin
    if (rst) vld1_q <= 1'b0;
    else     vld1_q <= in_vld;
  end

  always_comb begin
    rnd = (prod_q + RND) >>> GAIN_FRAC;
    if (rnd > HI)       sat_x = SAT_MAX;
    else if (rnd < LO)  sat_x = SAT_MIN;
    else                sat_x = rnd[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_x   <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= vld1_q;
      if (vld1_q) out_x <= sat_x;
    end
  end

endmodule

// File: rtl/rx_agc.sv
// Receive AGC: scales I/Q by a loop gain, averages |I|+|Q| per window and steps the gain toward i_pow_ref.
module rx_agc
  import rx_pkg::*;
#(
  parameter int unsigned WIN_LOG2  = 4,
  parameter int unsigned GAIN_INIT = 256,
  parameter int unsigned GAIN_MIN  = 16,
  parameter int unsigned GAIN_MAX  = 4095,
  parameter int unsigned GAIN_STEP = 4,
  parameter int unsigned HYST      = 32,
  parameter int unsigned LOCK_CNT  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_agc_en_n,
  input  logic        [15:0]         i_pow_ref,
  input  logic signed [SAMPLE_W-1:0] i_i,
  input  logic signed [SAMPLE_W-1:0] i_q,
  input  logic                       i_vld,
  output logic signed [SAMPLE_W-1:0] o_i,
  output logic signed [SAMPLE_W-1:0] o_q,
  output logic                       o_vld,
  output logic        [GAIN_W-1:0]   o_gain,
  output logic                       o_lock
);

  localparam int ACC_W = MAG_W + WIN_LOG2;
  localparam int LC_W  = $clog2(LOCK_CNT + 1);

  localparam logic [GAIN_W-1:0] G_INIT = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W-1:0] G_MIN  = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0] G_MAX  = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] G_STEP = GAIN_W'(GAIN_STEP);
  localparam logic [LC_W-1:0]   LC_TOP = LC_W'(LOCK_CNT);

  agc_state_e            state_q, state_d;
  logic [GAIN_W-1:0]     gain_q, gain_upd;
  logic [ACC_W-1:0]      acc_q, acc_sum;
  logic [WIN_LOG2-1:0]   cnt_q;
  logic [LC_W-1:0]       lock_cnt_q, lock_cnt_inc;
  logic                  lock_q;
  logic [MAG_W-1:0]      mag, avg, ref_hi, ref_lo;
  logic                  meas_en, in_band;
  logic                  vld_i, vld_q;

  agc_scale u_scale_i (
    .clk(i_clk), .rst(i_rst), .in_vld(i_vld), .in_x(i_i), .gain(gain_q),
    .out_x(o_i), .out_vld(vld_i)
  );

  agc_scale u_scale_q (
    .clk(i_clk), .rst(i_rst), .in_vld(i_vld), .in_x(i_q), .gain(gain_q),
    .out_x(o_q), .out_vld(vld_q)
  );

  assign o_vld  = vld_i & vld_q;
  assign o_gain = gain_q;
  assign o_lock = lock_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (!i_start)        state_d = AGC_IDLE;
    else if (i_agc_en_n) state_d = AGC_HOLD;
    else                 state_d = AGC_TRACK;
  end

  // Only samples that arrive while tracking both before and after the edge count toward a window.
  assign meas_en = o_vld && (state_q == AGC_TRACK) && (state_d == AGC_TRACK);

  always_comb begin
    mag     = MAG_W'(abs_sat(o_i)) + MAG_W'(abs_sat(o_q));
    acc_sum = acc_q + ACC_W'(mag);
    avg     = acc_sum[ACC_W-1:WIN_LOG2];
    ref_hi  = MAG_W'(i_pow_ref) + MAG_W'(HYST);
    ref_lo  = (i_pow_ref > 16'(HYST)) ? MAG_W'(i_pow_ref - 16'(HYST)) : '0;

    gain_upd = gain_q;
    in_band  = 1'b0;
    if (avg > ref_hi)
      gain_upd = (gain_q < G_MIN + G_STEP) ? G_MIN : gain_q - G_STEP;
    else if (avg < ref_lo)
      gain_upd = ({1'b0, gain_q} + {1'b0, G_STEP} > {1'b0, G_MAX}) ? G_MAX : gain_q + G_STEP;
    else
      in_band = 1'b1;

    lock_cnt_inc = (lock_cnt_q == LC_TOP) ? lock_cnt_q : lock_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= AGC_IDLE;
      gain_q     <= G_INIT;
      acc_q      <= '0;
      cnt_q      <= '0;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_d)
        AGC_IDLE: begin
          gain_q     <= G_INIT;
          acc_q      <= '0;
          cnt_q      <= '0;
          lock_cnt_q <= '0;
          lock_q     <= 1'b0;
        end
        AGC_HOLD: begin
          acc_q <= '0;
          cnt_q <= '0;
        end
        AGC_TRACK: begin
          if (meas_en) begin
            if (&cnt_q) begin
              acc_q  <= '0;
              cnt_q  <= '0;
              gain_q <= gain_upd;
              if (in_band) begin
                lock_cnt_q <= lock_cnt_inc;
                lock_q     <= (lock_cnt_inc == LC_TOP);
              end else begin
                lock_cnt_q <= '0;
                lock_q     <= 1'b0;
              end
            end else begin
              acc_q <= acc_sum;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
